// File: rtl/dual_dispatch_if.sv
// Instruction-side bundle between fetch, the result buses, the completion unit
// and the dual-issue dispatch unit.
interface dual_dispatch_if;
  logic        fetch_valid1;
  logic [31:0] fetch_inst1;
  logic [15:0] fetch_pc1;
  logic        fetch_valid2;
  logic [31:0] fetch_inst2;
  logic [15:0] fetch_pc2;
  logic        fetch_ready;
  logic [39:0] addbus;
  logic [39:0] multbus;
  logic [39:0] loadbus;
  logic        stall;
  logic        exception;
  logic [15:0] pc1;
  logic [15:0] pc2;
  logic [39:0] instbus1;
  logic [39:0] instbus2;
  logic        issue1;
  logic        issue2;
  logic [6:0]  busy;

  modport master (
    output fetch_valid1, fetch_inst1, fetch_pc1,
    output fetch_valid2, fetch_inst2, fetch_pc2,
    output addbus, multbus, loadbus, stall, exception,
    input  fetch_ready, pc1, pc2, instbus1, instbus2, issue1, issue2, busy
  );

  modport slave (
    input  fetch_valid1, fetch_inst1, fetch_pc1,
    input  fetch_valid2, fetch_inst2, fetch_pc2,
    input  addbus, multbus, loadbus, stall, exception,
    output fetch_ready, pc1, pc2, instbus1, instbus2, issue1, issue2, busy
  );
endinterface

// File: rtl/dual_dispatch.sv
// In-order dual-issue dispatch: instruction FIFO, reservation-station allocation
// and busy tracking, with stall handling and a sticky freeze on exception.
module dual_dispatch #(
  parameter int           DEPTH  = 8,
  parameter logic [7:0]   OP_ADD = 8'h01,
  parameter logic [7:0]   OP_SUB = 8'h02,
  parameter logic [7:0]   OP_MUL = 8'h03,
  parameter logic [7:0]   OP_LD  = 8'h04
) (
  input  logic          clk,
  input  logic          rst,
  dual_dispatch_if.slave io
);

  localparam int PW = $clog2(DEPTH);

  // Station tags; tag N owns busy bit N-1, tag 0 means no station.
  localparam logic [7:0] TAG_A0  = 8'd1;
  localparam logic [7:0] TAG_A2  = 8'd3;
  localparam logic [7:0] TAG_M0  = 8'd4;
  localparam logic [7:0] TAG_M1  = 8'd5;
  localparam logic [7:0] TAG_LD0 = 8'd6;
  localparam logic [7:0] TAG_LD1 = 8'd7;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_ADD  = 2'd1,
    CLS_MUL  = 2'd2,
    CLS_LD   = 2'd3
  } cls_e;

  function automatic cls_e class_of(input logic [7:0] op);
    cls_e c;
    if (op == OP_ADD || op == OP_SUB) c = CLS_ADD;
    else if (op == OP_MUL)            c = CLS_MUL;
    else if (op == OP_LD)             c = CLS_LD;
    else                              c = CLS_NONE;
    return c;
  endfunction

  // Lowest-numbered free station of the class, or 0 when the class is full.
  function automatic logic [7:0] pick_station(input logic [6:0] busy_mask, input cls_e cls);
    int lo;
    int hi;
    logic [7:0] tag;
    tag = '0;
    lo  = 0;
    hi  = -1;
    case (cls)
      CLS_ADD: begin lo = 0; hi = 2; end
      CLS_MUL: begin lo = 3; hi = 4; end
      CLS_LD:  begin lo = 5; hi = 6; end
      default: begin lo = 0; hi = -1; end
    endcase
    for (int i = 6; i >= 0; i--) begin
      if (i >= lo && i <= hi && !busy_mask[i]) tag = 8'(i + 1);
    end
    return tag;
  endfunction

  function automatic logic [6:0] clear_mask(input logic [7:0] tag, input logic [7:0] lo_tag,
                                            input logic [7:0] hi_tag);
    logic [6:0] m;
    m = '0;
    if (tag >= lo_tag && tag <= hi_tag) m = 7'(1) << (tag - 8'd1);
    return m;
  endfunction

  logic [47:0] fifo_mem [DEPTH];
  logic [PW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [6:0]  busy_q, busy_d;
  logic        frozen_q, frozen_d;
  logic        issue1_q, issue1_d, issue2_q, issue2_d;
  logic [39:0] instbus1_q, instbus1_d, instbus2_q, instbus2_d;
  logic [15:0] pc1_q, pc1_d, pc2_q, pc2_d;

  logic [PW:0] count;
  logic        ready;
  logic        push1, push2;
  logic [47:0] head, second;
  cls_e        cls1, cls2;
  logic [6:0]  avail, after1;
  logic [7:0]  tag1, tag2;
  logic        iss1, iss2;
  logic [1:0]  pop;
  logic [6:0]  set_mask;

  always_comb begin
    count  = wr_ptr_q - rd_ptr_q;
    ready  = !frozen_q && (count <= (PW+1)'(DEPTH - 2));
    push1  = io.fetch_valid1 && ready;
    push2  = push1 && io.fetch_valid2;
    head   = fifo_mem[rd_ptr_q[PW-1:0]];
    second = fifo_mem[PW'(rd_ptr_q[PW-1:0] + 1'b1)];
    cls1   = class_of(head[31:24]);
    cls2   = class_of(second[31:24]);

    // Broadcasts free stations before allocation so a freed tag is reusable at once.
    avail = busy_q
          & ~clear_mask(io.addbus[39:32],  TAG_A0,  TAG_A2)
          & ~clear_mask(io.multbus[39:32], TAG_M0,  TAG_M1)
          & ~clear_mask(io.loadbus[39:32], TAG_LD0, TAG_LD1);

    tag1     = '0;
    tag2     = '0;
    iss1     = 1'b0;
    iss2     = 1'b0;
    pop      = 2'd0;
    set_mask = '0;
    after1   = avail;
    if (!io.stall && !frozen_q && count != '0) begin
      if (cls1 == CLS_NONE) begin
        pop = 2'd1;
      end else begin
        tag1 = pick_station(avail, cls1);
        if (tag1 != '0) begin
          iss1     = 1'b1;
          pop      = 2'd1;
          set_mask = 7'(1) << (tag1 - 8'd1);
          after1   = avail | set_mask;
          if (count >= (PW+1)'(2) && cls2 != CLS_NONE) begin
            tag2 = pick_station(after1, cls2);
            if (tag2 != '0) begin
              iss2     = 1'b1;
              pop      = 2'd2;
              set_mask = set_mask | (7'(1) << (tag2 - 8'd1));
            end
          end
        end
      end
    end

    busy_d     = avail | set_mask;
    rd_ptr_d   = rd_ptr_q + (PW+1)'(pop);
    wr_ptr_d   = wr_ptr_q + (PW+1)'(push1) + (PW+1)'(push2);
    frozen_d   = frozen_q | io.exception;
    issue1_d   = iss1;
    issue2_d   = iss2;
    instbus1_d = iss1 ? {tag1, head[31:0]}   : instbus1_q;
    pc1_d      = iss1 ? head[47:32]          : pc1_q;
    instbus2_d = iss2 ? {tag2, second[31:0]} : instbus2_q;
    pc2_d      = iss2 ? second[47:32]        : pc2_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      busy_q     <= '0;
      frozen_q   <= 1'b0;
      issue1_q   <= 1'b0;
      issue2_q   <= 1'b0;
      instbus1_q <= '0;
      instbus2_q <= '0;
      pc1_q      <= '0;
      pc2_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      busy_q     <= busy_d;
      frozen_q   <= frozen_d;
      issue1_q   <= issue1_d;
      issue2_q   <= issue2_d;
      instbus1_q <= instbus1_d;
      instbus2_q <= instbus2_d;
      pc1_q      <= pc1_d;
      pc2_q      <= pc2_d;
    end
  end

  // Storage needs no reset; validity is carried entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push1) fifo_mem[wr_ptr_q[PW-1:0]] <= {io.fetch_pc1, io.fetch_inst1};
    if (push2) fifo_mem[PW'(wr_ptr_q[PW-1:0] + 1'b1)] <= {io.fetch_pc2, io.fetch_inst2};
  end

  assign io.fetch_ready = ready;
  assign io.busy        = busy_q;
  assign io.issue1      = issue1_q;
  assign io.issue2      = issue2_q;
  assign io.instbus1    = instbus1_q;
  assign io.instbus2    = instbus2_q;
  assign io.pc1         = pc1_q;
  assign io.pc2         = pc2_q;

endmodule

// File: tb/tb_dual_dispatch.sv
// Directed bench for dual_dispatch: expected issues are queued as stimulus is
// driven and matched against every strobe the DUT produces.
module tb_dual_dispatch;

  localparam logic [7:0] OP_ADD = 8'h01;
  localparam logic [7:0] OP_MUL = 8'h03;
  localparam logic [7:0] OP_LD  = 8'h04;
  localparam logic [7:0] OP_BAD = 8'h09;

  localparam logic [7:0] A0  = 8'd1;
  localparam logic [7:0] A1  = 8'd2;
  localparam logic [7:0] A2  = 8'd3;
  localparam logic [7:0] M0  = 8'd4;
  localparam logic [7:0] M1  = 8'd5;
  localparam logic [7:0] LD0 = 8'd6;
  localparam logic [7:0] LD1 = 8'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dual_dispatch_if dif ();

  dual_dispatch #(.DEPTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .io  (dif)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    int          slot;
    logic [39:0] bus;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];

  function automatic logic [31:0] mk(input logic [7:0] op, input logic [7:0] dest);
    return {op, 8'h01, 8'h02, dest};
  endfunction

  task automatic check_output(input string name, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input logic v1, input logic [31:0] i1, input logic [15:0] p1,
                                input logic v2, input logic [31:0] i2, input logic [15:0] p2);
    dif.fetch_valid1 = v1;
    dif.fetch_inst1  = i1;
    dif.fetch_pc1    = p1;
    dif.fetch_valid2 = v2;
    dif.fetch_inst2  = i2;
    dif.fetch_pc2    = p2;
  endtask

  task automatic idle();
    apply_stimulus(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  task automatic expect_issue(input int slot, input logic [7:0] tag, input logic [31:0] inst,
                              input logic [15:0] pc);
    exp_t e;
    e.slot = slot;
    e.bus  = {tag, inst};
    e.pc   = pc;
    exp_q.push_back(e);
  endtask

  task automatic sb_compare(input int slot, input logic [39:0] bus, input logic [15:0] pc);
    exp_t e;
    check_output("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check_output("sb_slot", 64'(slot), 64'(e.slot));
      check_output("sb_instbus", 64'(bus), 64'(e.bus));
      check_output("sb_pc", 64'(pc), 64'(e.pc));
    end
  endtask

  // Every strobe seen mid-cycle is matched, in order, against the queued issues.
  always @(negedge clk) begin
    if (!rst) begin
      if (dif.issue2) check_output("issue2_implies_issue1", 64'(dif.issue1), 64'd1);
      if (dif.issue1) sb_compare(1, dif.instbus1, dif.pc1);
      if (dif.issue2) sb_compare(2, dif.instbus2, dif.pc2);
    end
  end

  logic [7:0]  fill_op [7];
  logic [7:0]  fill_tag [7];

  initial begin
    rst           = 1'b1;
    dif.addbus    = '0;
    dif.multbus   = '0;
    dif.loadbus   = '0;
    dif.stall     = 1'b0;
    dif.exception = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_output("reset_busy", 64'(dif.busy), 64'd0);
    check_output("reset_issue1", 64'(dif.issue1), 64'd0);
    check_output("reset_issue2", 64'(dif.issue2), 64'd0);
    check_output("reset_instbus1", 64'(dif.instbus1), 64'd0);
    check_output("reset_pc2", 64'(dif.pc2), 64'd0);
    check_output("reset_ready", 64'(dif.fetch_ready), 64'd1);

    // Dual issue ADD + MUL
    apply_stimulus(1'b1, mk(OP_ADD, 8'h10), 16'h0010, 1'b1, mk(OP_MUL, 8'h11), 16'h0011);
    expect_issue(1, A0, mk(OP_ADD, 8'h10), 16'h0010);
    expect_issue(2, M0, mk(OP_MUL, 8'h11), 16'h0011);
    step();
    idle();
    check_output("no_bypass", 64'(dif.issue1), 64'd0);
    step();
    check_output("dual_issue1", 64'(dif.issue1), 64'd1);
    check_output("dual_issue2", 64'(dif.issue2), 64'd1);
    check_output("dual_busy", 64'(dif.busy), 64'h09);
    dif.addbus  = {A0, 32'h5};
    dif.multbus = {M0, 32'h7};
    step();
    dif.addbus  = '0;
    dif.multbus = '0;
    check_output("dual_freed", 64'(dif.busy), 64'd0);

    // Four ADDs: third adder exhausts the class, fourth waits for a broadcast
    apply_stimulus(1'b1, mk(OP_ADD, 8'h20), 16'h0020, 1'b1, mk(OP_ADD, 8'h21), 16'h0021);
    expect_issue(1, A0, mk(OP_ADD, 8'h20), 16'h0020);
    expect_issue(2, A1, mk(OP_ADD, 8'h21), 16'h0021);
    step();
    apply_stimulus(1'b1, mk(OP_ADD, 8'h22), 16'h0022, 1'b1, mk(OP_ADD, 8'h23), 16'h0023);
    expect_issue(1, A2, mk(OP_ADD, 8'h22), 16'h0022);
    step();
    idle();
    check_output("add_pair_issue2", 64'(dif.issue2), 64'd1);
    step();
    check_output("add3_issue1", 64'(dif.issue1), 64'd1);
    check_output("add3_issue2", 64'(dif.issue2), 64'd0);
    check_output("add3_busy", 64'(dif.busy), 64'h07);
    step();
    check_output("add4_blocked", 64'(dif.issue1), 64'd0);
    check_output("add4_hold_bus", 64'(dif.instbus1), 64'({A2, mk(OP_ADD, 8'h22)}));
    dif.addbus = {A1, 32'h5};
    expect_issue(1, A1, mk(OP_ADD, 8'h23), 16'h0023);
    step();
    dif.addbus = '0;
    check_output("add4_issued", 64'(dif.issue1), 64'd1);
    check_output("add4_busy_reuse", 64'(dif.busy), 64'h07);
    check_output("slot2_hold_pc", 64'(dif.pc2), 64'h0021);
    dif.addbus = {A0, 32'h0};
    step();
    dif.addbus = {A1, 32'h0};
    step();
    dif.addbus = {A2, 32'h0};
    step();
    dif.addbus = '0;
    check_output("adders_freed", 64'(dif.busy), 64'd0);

    // LD + ADD under a three-cycle stall
    dif.stall = 1'b1;
    apply_stimulus(1'b1, mk(OP_LD, 8'h30), 16'h0030, 1'b1, mk(OP_ADD, 8'h31), 16'h0031);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("stall_no_issue", 64'(dif.issue1), 64'd0);
      check_output("stall_hold_pc1", 64'(dif.pc1), 64'h0023);
    end
    expect_issue(1, LD0, mk(OP_LD, 8'h30), 16'h0030);
    expect_issue(2, A0, mk(OP_ADD, 8'h31), 16'h0031);
    dif.stall = 1'b0;
    step();
    check_output("unstall_issue2", 64'(dif.issue2), 64'd1);
    check_output("unstall_busy", 64'(dif.busy), 64'h21);
    dif.loadbus = {LD0, 32'h1};
    dif.addbus  = {A0, 32'h2};
    step();
    dif.loadbus = '0;
    dif.addbus  = '0;
    check_output("unstall_freed", 64'(dif.busy), 64'd0);

    // Unknown opcode at the head is dropped without an issue
    apply_stimulus(1'b1, mk(OP_BAD, 8'h40), 16'h0040, 1'b1, mk(OP_ADD, 8'h41), 16'h0041);
    step();
    idle();
    step();
    check_output("drop_no_issue", 64'(dif.issue1), 64'd0);
    expect_issue(1, A0, mk(OP_ADD, 8'h41), 16'h0041);
    step();
    check_output("after_drop_issue", 64'(dif.issue1), 64'd1);
    check_output("after_drop_slot2", 64'(dif.issue2), 64'd0);
    dif.addbus = {A0, 32'h0};
    step();
    dif.addbus = '0;

    // Fill under stall, then drain across the pointer wrap
    fill_op  = '{OP_ADD, OP_MUL, OP_LD, OP_ADD, OP_MUL, OP_LD, OP_ADD};
    fill_tag = '{A0, M0, LD0, A1, M1, LD1, A2};
    dif.stall = 1'b1;
    for (int i = 0; i < 6; i += 2) begin
      apply_stimulus(1'b1, mk(fill_op[i], 8'(8'h50 + i)), 16'(16'h0050 + i),
                     1'b1, mk(fill_op[i+1], 8'(8'h51 + i)), 16'(16'h0051 + i));
      step();
    end
    idle();
    check_output("ready_at_6", 64'(dif.fetch_ready), 64'd1);
    apply_stimulus(1'b1, mk(fill_op[6], 8'h56), 16'h0056, 1'b0, '0, '0);
    step();
    idle();
    check_output("ready_at_7", 64'(dif.fetch_ready), 64'd0);
    for (int i = 0; i < 7; i++) begin
      expect_issue((i % 2) + 1, fill_tag[i], mk(fill_op[i], 8'(8'h50 + i)), 16'(16'h0050 + i));
    end
    dif.stall = 1'b0;
    repeat (4) step();
    check_output("drain_busy_full", 64'(dif.busy), 64'h7F);
    check_output("drain_ready", 64'(dif.fetch_ready), 64'd1);

    // Mid-run reset with all stations busy and three entries queued
    apply_stimulus(1'b1, mk(OP_ADD, 8'h60), 16'h0060, 1'b1, mk(OP_ADD, 8'h61), 16'h0061);
    step();
    apply_stimulus(1'b1, mk(OP_ADD, 8'h62), 16'h0062, 1'b0, '0, '0);
    step();
    idle();
    step();
    check_output("pre_reset_blocked", 64'(dif.issue1), 64'd0);
    rst = 1'b1;
    #1;
    check_output("midreset_busy", 64'(dif.busy), 64'd0);
    check_output("midreset_issue1", 64'(dif.issue1), 64'd0);
    check_output("midreset_instbus1", 64'(dif.instbus1), 64'd0);
    check_output("midreset_instbus2", 64'(dif.instbus2), 64'd0);
    check_output("midreset_ready", 64'(dif.fetch_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    step();
    check_output("reset_flushed_fifo", 64'(dif.issue1), 64'd0);

    // Exception freezes dispatch; result buses still free stations
    apply_stimulus(1'b1, mk(OP_LD, 8'h70), 16'h0070, 1'b0, '0, '0);
    expect_issue(1, LD0, mk(OP_LD, 8'h70), 16'h0070);
    step();
    idle();
    step();
    check_output("pre_exc_busy", 64'(dif.busy), 64'h20);
    dif.exception = 1'b1;
    step();
    dif.exception = 1'b0;
    check_output("frozen_ready", 64'(dif.fetch_ready), 64'd0);
    apply_stimulus(1'b1, mk(OP_ADD, 8'h71), 16'h0071, 1'b0, '0, '0);
    step();
    step();
    idle();
    check_output("frozen_no_issue", 64'(dif.issue1), 64'd0);
    check_output("frozen_hold_pc1", 64'(dif.pc1), 64'h0070);
    dif.loadbus = {LD0, 32'hffffffff};
    step();
    dif.loadbus = '0;
    check_output("page_fault_frees", 64'(dif.busy), 64'd0);
    repeat (2) step();
    check_output("frozen_sticky", 64'(dif.fetch_ready), 64'd0);
    check_output("frozen_still_idle", 64'(dif.issue1), 64'd0);
    check_output("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
